// File: rtl/regfile_mp.sv
// Multi-port register file: NREAD combinational read ports, two byte-enabled
// write ports (port 1 wins overlapping bytes), optional bypass and zero register.
module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH),
  localparam int NB      = WIDTH / 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   WriteEnable0,
  input  logic [AW-1:0]          WriteRegister0,
  input  logic [WIDTH-1:0]       WriteData0,
  input  logic [NB-1:0]          ByteEnable0,
  input  logic                   WriteEnable1,
  input  logic [AW-1:0]          WriteRegister1,
  input  logic [WIDTH-1:0]       WriteData1,
  input  logic [NB-1:0]          ByteEnable1,
  input  logic [NREAD*AW-1:0]    ReadRegister,
  output logic [NREAD*WIDTH-1:0] ReadData
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Post-edge value of register a given this cycle's write inputs; port 1 is
  // applied last so it owns bytes enabled on both ports.
  function automatic logic [WIDTH-1:0] merged(input logic [WIDTH-1:0] old,
                                              input logic [AW-1:0]    a);
    logic [WIDTH-1:0] v;
    v = old;
    for (int unsigned i = 0; i < NB; i++) begin
      if (WriteEnable0 && WriteRegister0 == a && ByteEnable0[i])
        v[8*i +: 8] = WriteData0[8*i +: 8];
      if (WriteEnable1 && WriteRegister1 == a && ByteEnable1[i])
        v[8*i +: 8] = WriteData1[8*i +: 8];
    end
    return v;
  endfunction

  for (genvar r = 0; r < DEPTH; r++) begin : g_reg
    always_ff @(posedge clk) begin
      if (!rst_n || (ZERO_REG != 0 && r == 0))
        mem[r] <= '0;
      else
        mem[r] <= merged(mem[r], AW'(r));
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_read
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] lane;

    assign addr = ReadRegister[k*AW +: AW];

    always_comb begin
      lane = mem[addr];
      if (BYPASS != 0)
        lane = merged(mem[addr], addr);
      if (!rst_n || (ZERO_REG != 0 && addr == '0))
        lane = '0;
    end

    assign ReadData[k*WIDTH +: WIDTH] = lane;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed table, reset and wide-config
// sequences, and randomized traffic against an array-based reference model.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the 32x32 instances (a: bypass+zero reg, b: neither)
  logic        rst_n;
  logic        we0, we1;
  logic [4:0]  wa0, wa1, ra0, ra1;
  logic [31:0] wd0, wd1;
  logic [3:0]  be0, be1;
  logic [9:0]  rr;
  logic [63:0] rd_a, rd_b;
  assign rr = {ra1, ra0};

  // Wide configuration instance
  logic         cwe0, cwe1;
  logic [2:0]   cwa0, cwa1;
  logic [63:0]  cwd0, cwd1;
  logic [7:0]   cbe0, cbe1;
  logic [8:0]   crr;
  logic [191:0] crd;

  regfile_mp #(.WIDTH(32), .DEPTH(32), .NREAD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .WriteEnable0(we0), .WriteRegister0(wa0), .WriteData0(wd0), .ByteEnable0(be0),
    .WriteEnable1(we1), .WriteRegister1(wa1), .WriteData1(wd1), .ByteEnable1(be1),
    .ReadRegister(rr), .ReadData(rd_a));

  regfile_mp #(.WIDTH(32), .DEPTH(32), .NREAD(2), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .WriteEnable0(we0), .WriteRegister0(wa0), .WriteData0(wd0), .ByteEnable0(be0),
    .WriteEnable1(we1), .WriteRegister1(wa1), .WriteData1(wd1), .ByteEnable1(be1),
    .ReadRegister(rr), .ReadData(rd_b));

  regfile_mp #(.WIDTH(64), .DEPTH(8), .NREAD(3), .ZERO_REG(1), .BYPASS(1)) dut_c (
    .clk(clk), .rst_n(rst_n),
    .WriteEnable0(cwe0), .WriteRegister0(cwa0), .WriteData0(cwd0), .ByteEnable0(cbe0),
    .WriteEnable1(cwe1), .WriteRegister1(cwa1), .WriteData1(cwd1), .ByteEnable1(cbe1),
    .ReadRegister(crr), .ReadData(crd));

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: register contents as plain arrays, writes as mask arithmetic.
  logic [31:0] model_a [32];
  logic [31:0] model_b [32];

  function automatic logic [31:0] bmask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  function automatic logic [31:0] after_edge(input logic [31:0] old, input logic [4:0] a,
                                             input bit zero);
    logic [31:0] v;
    v = old;
    if (zero && a == 5'd0) return old;
    if (we0 && wa0 == a) v = (v & ~bmask(be0)) | (wd0 & bmask(be0));
    if (we1 && wa1 == a) v = (v & ~bmask(be1)) | (wd1 & bmask(be1));
    return v;
  endfunction

  function automatic logic [31:0] exp_a(input logic [4:0] a);
    if (!rst_n || a == 5'd0) return 32'h0;
    return after_edge(model_a[a], a, 1'b1);
  endfunction

  function automatic logic [31:0] exp_b(input logic [4:0] a);
    if (!rst_n) return 32'h0;
    return model_b[a];
  endfunction

  // Called just after an edge with inputs set: checks reads mid-cycle,
  // advances the model, and returns just after the next edge.
  task automatic cycle(input string tag, input bit has_exp,
                       input logic [31:0] e0, input logic [31:0] e1);
    #4;
    check({tag, "/a0"}, rd_a[31:0],  exp_a(ra0));
    check({tag, "/a1"}, rd_a[63:32], exp_a(ra1));
    check({tag, "/b0"}, rd_b[31:0],  exp_b(ra0));
    check({tag, "/b1"}, rd_b[63:32], exp_b(ra1));
    if (has_exp) begin
      check({tag, "/tbl0"}, rd_a[31:0],  e0);
      check({tag, "/tbl1"}, rd_a[63:32], e1);
    end
    for (int r = 0; r < 32; r++) begin
      if (!rst_n) begin
        model_a[r] = '0;
        model_b[r] = '0;
      end else begin
        model_a[r] = after_edge(model_a[r], 5'(r), 1'b1);
        model_b[r] = after_edge(model_b[r], 5'(r), 1'b0);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; be0 = '0; be1 = '0;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
  endtask

  typedef struct {
    logic        we0; logic [4:0] wa0; logic [31:0] wd0; logic [3:0] be0;
    logic        we1; logic [4:0] wa1; logic [31:0] wd1; logic [3:0] be1;
    logic [4:0]  ra0; logic [4:0] ra1;
    logic [31:0] e0;  logic [31:0] e1;
  } vec_t;

  vec_t tbl [7];

  function automatic logic [63:0] cval(input int i);
    return {32'hC0DE0000 | 32'(i), 32'h5A5A0000 ^ (32'(i) * 32'h111)};
  endfunction

  initial begin
    tbl[0] = '{1, 5'd3, 32'h11223344, 4'hF, 0, 5'd0, 32'h0, 4'h0, 5'd3, 5'd0, 32'h11223344, 32'h0};
    tbl[1] = '{1, 5'd3, 32'hAABBCCDD, 4'h5, 0, 5'd0, 32'h0, 4'h0, 5'd3, 5'd3, 32'h11BB33DD, 32'h11BB33DD};
    tbl[2] = '{1, 5'd7, 32'h000000FF, 4'hF, 1, 5'd7, 32'h12340000, 4'hC, 5'd7, 5'd3, 32'h123400FF, 32'h11BB33DD};
    tbl[3] = '{1, 5'd9, 32'h00000055, 4'hF, 0, 5'd0, 32'h0, 4'h0, 5'd7, 5'd9, 32'h123400FF, 32'h00000055};
    tbl[4] = '{1, 5'd0, 32'hFFFFFFFF, 4'hF, 1, 5'd0, 32'hFFFFFFFF, 4'hF, 5'd0, 5'd0, 32'h0, 32'h0};
    tbl[5] = '{0, 5'd0, 32'h0, 4'h0, 0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd9, 32'h0, 32'h00000055};
    tbl[6] = '{0, 5'd0, 32'h0, 4'h0, 0, 5'd0, 32'h0, 4'h0, 5'd3, 5'd7, 32'h11BB33DD, 32'h123400FF};

    for (int r = 0; r < 32; r++) begin model_a[r] = '0; model_b[r] = '0; end
    rst_n = 0; idle(); ra0 = 5'd5; ra1 = 5'd6;
    cwe0 = 0; cwe1 = 0; cwa0 = '0; cwa1 = '0; cwd0 = '0; cwd1 = '0; cbe0 = '0; cbe1 = '0;
    crr = {3'd7, 3'd4, 3'd1};
    @(posedge clk); #1;
    cycle("rst_init", 0, 0, 0);
    check("rst_init/c", crd, 192'h0);

    // Reset clears contents and drops a write issued during reset
    rst_n = 1;
    we0 = 1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; be0 = 4'hF;
    cycle("pre_rst", 0, 0, 0);
    rst_n = 0;
    we0 = 1; wa0 = 5'd6; wd0 = 32'hCAFEF00D; be0 = 4'hF;
    cycle("in_rst", 1, 32'h0, 32'h0);
    rst_n = 1; idle();
    cycle("post_rst", 1, 32'h0, 32'h0);

    for (int i = 0; i < 7; i++) begin
      we0 = tbl[i].we0; wa0 = tbl[i].wa0; wd0 = tbl[i].wd0; be0 = tbl[i].be0;
      we1 = tbl[i].we1; wa1 = tbl[i].wa1; wd1 = tbl[i].wd1; be1 = tbl[i].be1;
      ra0 = tbl[i].ra0; ra1 = tbl[i].ra1;
      cycle($sformatf("tbl%0d", i), 1, tbl[i].e0, tbl[i].e1);
    end
    idle();

    // Wide configuration: fill all 8 registers, then read distinct triples
    for (int j = 0; j < 4; j++) begin
      cwe0 = 1; cwa0 = 3'(2*j);   cwd0 = cval(2*j);   cbe0 = 8'hFF;
      cwe1 = 1; cwa1 = 3'(2*j+1); cwd1 = cval(2*j+1); cbe1 = 8'hFF;
      @(posedge clk); #1;
    end
    cwe0 = 0; cwe1 = 0;
    for (int t = 0; t < 4; t++) begin
      automatic int x0 = t;
      automatic int x1 = (t + 3) % 8;
      automatic int x2 = 7 - t;
      crr = {3'(x2), 3'(x1), 3'(x0)};
      #4;
      check($sformatf("wide%0d/l0", t), crd[63:0],    (x0 == 0) ? 64'h0 : cval(x0));
      check($sformatf("wide%0d/l1", t), crd[127:64],  (x1 == 0) ? 64'h0 : cval(x1));
      check($sformatf("wide%0d/l2", t), crd[191:128], (x2 == 0) ? 64'h0 : cval(x2));
      @(posedge clk); #1;
    end

    // Randomized traffic, addresses biased low to provoke conflicts and bypass hits
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      we0 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
      wa0 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
      wa1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
      ra0 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
      ra1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
      wd0 = $urandom; wd1 = $urandom;
      be0 = 4'($urandom); be1 = 4'($urandom);
      cycle("rnd", 0, 0, 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
